// File: rtl/sentinel_pkg.sv
// Shared types and display constants for the Sentinel sequence lock.
package sentinel_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_COLLECT,
        ST_UNLOCKED,
        ST_LOCKOUT
    } sentinel_state_t;

    localparam logic [7:0] SEG_LOCKED   = 8'hC7;
    localparam logic [7:0] SEG_UNLOCKED = 8'hC1;
    localparam logic [7:0] SEG_LOCKOUT  = 8'hBF;
    localparam logic [7:0] SEG_OFF      = 8'hFF;

    localparam logic [7:0] GLOW_ON  = 8'hFF;
    localparam logic [7:0] GLOW_OFF = 8'h00;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sentinel_timer.sv
// Loadable down-counter; expire flags the edge on which the count goes 1->0.
module sentinel_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/sentinel_seq_lock.sv
// Multi-digit sequence lock with failure counting, timed lockout and status display.
module sentinel_seq_lock
    import sentinel_pkg::*;
#(
    parameter int                         KEY_W       = 8,
    parameter int                         KEY_LEN     = 4,
    parameter logic [KEY_LEN*KEY_W-1:0]   KEY         = 32'hB61F7AC3,
    parameter int                         MAX_FAILS   = 3,
    parameter int                         ENTRY_TO    = 255,
    parameter int                         UNLOCK_CYC  = 1000,
    parameter int                         LOCKOUT_CYC = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [KEY_W-1:0]                 key_in,
    input  logic                             key_valid,
    input  logic                             relock,
    input  logic                             ena,
    output logic                             unlocked,
    output logic                             lockout,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
    output logic [$clog2(KEY_LEN+1)-1:0]     digit_cnt,
    output logic [7:0]                       seg_out,
    output logic [7:0]                       glow
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int DW = $clog2(KEY_LEN + 1);
    localparam int TW = $clog2(max3(ENTRY_TO, UNLOCK_CYC, LOCKOUT_CYC) + 1);

    localparam logic [DW-1:0] KLEN      = DW'(KEY_LEN);
    localparam logic [FW-1:0] MAXF      = FW'(MAX_FAILS);
    localparam logic [TW-1:0] T_ENTRY   = TW'(ENTRY_TO);
    localparam logic [TW-1:0] T_UNLOCK  = TW'(UNLOCK_CYC);
    localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYC);

    sentinel_state_t state_q, state_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic            mis_q, mis_d;
    logic            unl_q, lo_q;

    logic            tmr_load, tmr_exp, eval;
    logic [TW-1:0]   tmr_val;
    logic [DW-1:0]   idx;
    logic [KEY_W-1:0] want;

    sentinel_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .value  (tmr_val),
        .expire (tmr_exp)
    );

    // Only one stored digit is compared per strobe; the verdict waits for the last one.
    assign idx  = (state_q == ST_COLLECT) ? dcnt_q : '0;
    assign want = KEY[(KEY_LEN - 1 - int'(idx)) * KEY_W +: KEY_W];

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        dcnt_d   = dcnt_q;
        mis_d    = mis_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        eval     = 1'b0;
        unique case (state_q)
            ST_LOCKED: begin
                if (key_valid) begin
                    dcnt_d = DW'(1);
                    mis_d  = (key_in != want);
                    if (dcnt_d == KLEN) begin
                        eval = 1'b1;
                    end else begin
                        state_d  = ST_COLLECT;
                        tmr_load = 1'b1;
                        tmr_val  = T_ENTRY;
                    end
                end
            end
            ST_COLLECT: begin
                if (key_valid) begin
                    dcnt_d = dcnt_q + DW'(1);
                    mis_d  = mis_q | (key_in != want);
                    if (dcnt_d == KLEN) begin
                        eval = 1'b1;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = T_ENTRY;
                    end
                end else if (tmr_exp) begin
                    eval  = 1'b1;
                    mis_d = 1'b1;
                end
            end
            ST_UNLOCKED: begin
                if (relock || tmr_exp) state_d = ST_LOCKED;
            end
            ST_LOCKOUT: begin
                if (tmr_exp) begin
                    state_d = ST_LOCKED;
                    fail_d  = '0;
                end
            end
            default: ;
        endcase
        if (eval) begin
            dcnt_d = '0;
            if (!mis_d) begin
                state_d  = ST_UNLOCKED;
                fail_d   = '0;
                tmr_load = 1'b1;
                tmr_val  = T_UNLOCK;
            end else begin
                fail_d = (fail_q == MAXF) ? fail_q : fail_q + FW'(1);
                if (fail_d == MAXF) begin
                    state_d  = ST_LOCKOUT;
                    tmr_load = 1'b1;
                    tmr_val  = T_LOCKOUT;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            mis_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOCKED;
            fail_q  <= '0;
            dcnt_q  <= '0;
            mis_q   <= 1'b0;
            unl_q   <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            dcnt_q  <= dcnt_d;
            mis_q   <= mis_d;
            unl_q   <= (state_d == ST_UNLOCKED);
            lo_q    <= (state_d == ST_LOCKOUT);
        end
    end

    always_comb begin
        seg_out = SEG_OFF;
        if (ena) begin
            unique case (state_q)
                ST_UNLOCKED: seg_out = SEG_UNLOCKED;
                ST_LOCKOUT:  seg_out = SEG_LOCKOUT;
                default:     seg_out = SEG_LOCKED;
            endcase
        end
    end

    assign glow      = (unl_q && ena) ? GLOW_ON : GLOW_OFF;
    assign unlocked  = unl_q;
    assign lockout   = lo_q;
    assign fail_cnt  = fail_q;
    assign digit_cnt = dcnt_q;

endmodule

// File: tb/tb_sentinel_seq_lock.sv
// Bench for sentinel_seq_lock: vector table, corner sequences, random run vs. model.
module tb_sentinel_seq_lock;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_in = 8'h00;
    logic       key_valid = 1'b0;
    logic       relock = 1'b0;
    logic       ena = 1'b1;
    logic       unlocked, lockout;
    logic [1:0] fail_cnt;
    logic [2:0] digit_cnt;
    logic [7:0] seg_out, glow;

    int checks = 0;
    int failures = 0;

    sentinel_seq_lock dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .relock    (relock),
        .ena       (ena),
        .unlocked  (unlocked),
        .lockout   (lockout),
        .fail_cnt  (fail_cnt),
        .digit_cnt (digit_cnt),
        .seg_out   (seg_out),
        .glow      (glow)
    );

    always #5 clk = ~clk;

    logic [7:0] secret [4] = '{8'hB6, 8'h1F, 8'h7A, 8'hC3};

    // Reference model: mode 0 locked, 1 entering, 2 open, 3 lockout.
    int         m_mode, m_fails, m_t, m_dl;
    logic [7:0] m_q [$];

    task automatic model_reset();
        m_mode = 0; m_fails = 0; m_t = 0; m_dl = -1;
        m_q.delete();
    endtask

    task automatic model_verdict(input bit pass);
        m_q.delete();
        if (pass) begin
            m_mode = 2; m_fails = 0; m_dl = m_t + 1000;
        end else begin
            m_fails++;
            if (m_fails >= 3) begin
                m_fails = 3; m_mode = 3; m_dl = m_t + 1024;
            end else begin
                m_mode = 0;
            end
        end
    endtask

    task automatic model_take(input logic [7:0] k);
        bit ok;
        m_q.push_back(k);
        if (m_q.size() == 4) begin
            ok = 1'b1;
            foreach (m_q[i]) if (m_q[i] != secret[i]) ok = 1'b0;
            model_verdict(ok);
        end else begin
            m_mode = 1; m_dl = m_t + 255;
        end
    endtask

    task automatic model_step(input logic kv, input logic [7:0] k, input logic rl);
        m_t++;
        case (m_mode)
            0: if (kv) model_take(k);
            1: begin
                if (kv) model_take(k);
                else if (m_t == m_dl) model_verdict(1'b0);
            end
            2: if (rl || m_t == m_dl) m_mode = 0;
            3: if (m_t == m_dl) begin m_mode = 0; m_fails = 0; end
            default: ;
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [7:0] es;
        es = !ena ? 8'hFF : (m_mode == 2) ? 8'hC1 : (m_mode == 3) ? 8'hBF : 8'hC7;
        chk({tag, "_unl"}, unlocked, m_mode == 2);
        chk({tag, "_lo"}, lockout, m_mode == 3);
        chk({tag, "_fail"}, fail_cnt, m_fails);
        chk({tag, "_dc"}, digit_cnt, m_q.size());
        chk({tag, "_seg"}, seg_out, es);
        chk({tag, "_glow"}, glow, (m_mode == 2 && ena) ? 8'hFF : 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(key_valid, key_in, relock);
        #1;
    endtask

    task automatic strobe(input logic [7:0] k, input int idle);
        key_valid = 1'b1; key_in = k;
        tick();
        key_valid = 1'b0;
        repeat (idle) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; key_valid = 1'b0; relock = 1'b0; ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       kv;
        logic [7:0] key;
        logic       rl;
        logic       en;
        logic       unl;
        logic       lo;
        logic [1:0] fails;
        logic [2:0] dc;
        logic [7:0] seg;
        logic [7:0] glw;
    } vec_t;

    vec_t vt [12];
    int   n;

    initial begin
        vt[0]  = '{1, 8'hB6, 0, 1, 0, 0, 0, 1, 8'hC7, 8'h00};
        vt[1]  = '{1, 8'h1F, 0, 1, 0, 0, 0, 2, 8'hC7, 8'h00};
        vt[2]  = '{1, 8'h7A, 0, 1, 0, 0, 0, 3, 8'hC7, 8'h00};
        vt[3]  = '{1, 8'hC3, 0, 1, 1, 0, 0, 0, 8'hC1, 8'hFF};
        vt[4]  = '{1, 8'h00, 0, 1, 1, 0, 0, 0, 8'hC1, 8'hFF};
        vt[5]  = '{0, 8'h00, 0, 0, 1, 0, 0, 0, 8'hFF, 8'h00};
        vt[6]  = '{0, 8'h00, 1, 1, 0, 0, 0, 0, 8'hC7, 8'h00};
        vt[7]  = '{1, 8'hB6, 0, 1, 0, 0, 0, 1, 8'hC7, 8'h00};
        vt[8]  = '{1, 8'h00, 0, 1, 0, 0, 0, 2, 8'hC7, 8'h00};
        vt[9]  = '{1, 8'h7A, 0, 1, 0, 0, 0, 3, 8'hC7, 8'h00};
        vt[10] = '{1, 8'hC3, 0, 1, 0, 0, 1, 0, 8'hC7, 8'h00};
        vt[11] = '{0, 8'h00, 0, 1, 0, 0, 1, 0, 8'hC7, 8'h00};

        // Reset values, with and without display enable
        #2;
        chk("rst_unl", unlocked, 1'b0);
        chk("rst_lo", lockout, 1'b0);
        chk("rst_fail", fail_cnt, 2'd0);
        chk("rst_dc", digit_cnt, 3'd0);
        chk("rst_seg_en", seg_out, 8'hC7);
        chk("rst_glow", glow, 8'h00);
        ena = 1'b0; #1;
        chk("rst_seg_dis", seg_out, 8'hFF);
        do_reset();

        foreach (vt[i]) begin
            key_valid = vt[i].kv; key_in = vt[i].key;
            relock = vt[i].rl; ena = vt[i].en;
            tick();
            chk($sformatf("vec%0d_unl", i), unlocked, vt[i].unl);
            chk($sformatf("vec%0d_lo", i), lockout, vt[i].lo);
            chk($sformatf("vec%0d_fail", i), fail_cnt, vt[i].fails);
            chk($sformatf("vec%0d_dc", i), digit_cnt, vt[i].dc);
            chk($sformatf("vec%0d_seg", i), seg_out, vt[i].seg);
            chk($sformatf("vec%0d_glow", i), glow, vt[i].glw);
        end
        key_valid = 1'b0; relock = 1'b0; ena = 1'b1;

        // Correct key every 3 cycles, then auto-relock after 1000 cycles
        do_reset();
        strobe(8'hB6, 2); strobe(8'h1F, 2); strobe(8'h7A, 2);
        chk("ok_pre_unl", unlocked, 1'b0);
        strobe(8'hC3, 0);
        chk("ok_unl", unlocked, 1'b1);
        chk("ok_seg", seg_out, 8'hC1);
        chk("ok_glow", glow, 8'hFF);
        chk("ok_fail", fail_cnt, 2'd0);
        n = 0;
        do begin tick(); n++; end while (unlocked && n < 1100);
        chk("hold_len", n, 1000);
        chk("hold_seg", seg_out, 8'hC7);

        // Wrong second digit: no verdict until the fourth digit
        strobe(8'hB6, 2);
        chk("leak1_seg", seg_out, 8'hC7);
        strobe(8'h00, 2);
        chk("leak2_seg", seg_out, 8'hC7);
        chk("leak2_dc", digit_cnt, 3'd2);
        strobe(8'h7A, 2);
        chk("leak3_fail", fail_cnt, 2'd0);
        strobe(8'hC3, 0);
        chk("leak_fail", fail_cnt, 2'd1);
        chk("leak_dc", digit_cnt, 3'd0);
        chk("leak_unl", unlocked, 1'b0);

        // Two more failures: lockout, correct key and relock ignored, 1024 cycles
        repeat (8) strobe(8'h00, 0);
        chk("lo_on", lockout, 1'b1);
        chk("lo_seg", seg_out, 8'hBF);
        chk("lo_fail", fail_cnt, 2'd3);
        n = 0;
        do begin
            key_valid = (n < 4); key_in = secret[n % 4]; relock = (n == 2);
            tick(); n++;
        end while (lockout && n < 1100);
        key_valid = 1'b0; relock = 1'b0;
        chk("lo_len", n, 1024);
        chk("lo_unl", unlocked, 1'b0);
        chk("lo_end_fail", fail_cnt, 2'd0);
        chk("lo_end_seg", seg_out, 8'hC7);

        // Idle timeout after two digits
        strobe(8'hB6, 2); strobe(8'h1F, 0);
        n = 0;
        do begin tick(); n++; end while (digit_cnt != 3'd0 && n < 300);
        chk("to_len", n, 255);
        chk("to_fail", fail_cnt, 2'd1);
        chk("to_seg", seg_out, 8'hC7);

        // Strobe on the expiry edge is accepted
        strobe(8'hB6, 254);
        strobe(8'h1F, 0);
        chk("to_race_dc", digit_cnt, 3'd2);
        chk("to_race_fail", fail_cnt, 2'd1);

        // Reset in the middle of lockout
        do_reset();
        repeat (12) strobe(8'h11, 0);
        repeat (10) tick();
        chk("rlo_on", lockout, 1'b1);
        rst = 1'b1; #1;
        chk("rlo_lo", lockout, 1'b0);
        chk("rlo_fail", fail_cnt, 2'd0);
        chk("rlo_dc", digit_cnt, 3'd0);
        chk("rlo_seg", seg_out, 8'hC7);
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // Random traffic against the model
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                key_valid = 1'b0; relock = 1'b0;
                repeat (260) tick();
            end
            key_valid = ($urandom_range(0, 2) == 0);
            key_in = ($urandom_range(0, 3) != 0) ? secret[m_q.size() % 4] : 8'($urandom);
            relock = ($urandom_range(0, 49) == 0);
            ena = ($urandom_range(0, 7) != 0);
            tick();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
